// File: rtl/shared_resource_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sched_pkg
// Description : Shared types, constants and the round-robin pick helper for
//               the shared resource scheduler.
//               REQ_ID_W : width of a requester id inside the tag pipe
//               CNT_W    : width of the burst counter
// Revision    : 1.0  initial release
// ============================================================================
package sched_pkg;

  localparam int MAX_NUM_REQ = 8;
  localparam int REQ_ID_W    = 3;
  localparam int CNT_W       = 4;

  // One in-flight op: valid = an op was issued, kill = its result is dropped.
  typedef struct packed {
    logic                valid;
    logic                kill;
    logic [REQ_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_DRAIN        = 2'd1,
    ST_IDLE_DRAINED = 2'd2
  } sched_state_t;

  // First eligible requester at or after ptr, wrapping at n.
  // Result: {found, index}.
  function automatic logic [REQ_ID_W:0] rr_pick(
    input logic [MAX_NUM_REQ-1:0] eligible,
    input logic [REQ_ID_W-1:0]    ptr,
    input int                     n
  );
    logic [REQ_ID_W:0] res;
    int                j;
    res = '0;
    // Walk from the far end back towards ptr so the last hit is the nearest.
    for (int k = MAX_NUM_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (eligible[j[REQ_ID_W-1:0]]) res = {1'b1, j[REQ_ID_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_resource_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : shared_resource_scheduler_if
// Description : Handshake bundle between the pipelines/resource and the
//               scheduler.
//               master : pipelines + resource side (drives requests/results)
//               slave  : scheduler side (drives grants/responses/status)
//               Optional macro SCHED_PERF_CNT_EN adds perf_grants/perf_stalls.
// Revision    : 1.0  initial release
// ============================================================================
interface shared_resource_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 3
);
  localparam int c_SEL_W = $clog2(NUM_REQ);
  localparam int c_IFL_W = $clog2(LATENCY + 1);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_flush;
  logic               res_ready;
  logic               res_out_valid;
  logic               drain_req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] stall;
  logic               res_in_valid;
  logic [c_SEL_W-1:0] res_in_sel;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [c_IFL_W-1:0] inflight_cnt;
  logic               drain_done;
  logic               err_rsp;
`ifdef SCHED_PERF_CNT_EN
  logic [NUM_REQ*16-1:0] perf_grants;
  logic [NUM_REQ*16-1:0] perf_stalls;

  modport master (
    output req, req_flush, res_ready, res_out_valid, drain_req,
    input  grant, stall, res_in_valid, res_in_sel, rsp_valid,
           inflight_cnt, drain_done, err_rsp, perf_grants, perf_stalls
  );
  modport slave (
    input  req, req_flush, res_ready, res_out_valid, drain_req,
    output grant, stall, res_in_valid, res_in_sel, rsp_valid,
           inflight_cnt, drain_done, err_rsp, perf_grants, perf_stalls
  );
`else
  modport master (
    output req, req_flush, res_ready, res_out_valid, drain_req,
    input  grant, stall, res_in_valid, res_in_sel, rsp_valid,
           inflight_cnt, drain_done, err_rsp
  );
  modport slave (
    input  req, req_flush, res_ready, res_out_valid, drain_req,
    output grant, stall, res_in_valid, res_in_sel, rsp_valid,
           inflight_cnt, drain_done, err_rsp
  );
`endif
endinterface
`default_nettype wire

// File: rtl/shared_resource_scheduler_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sched_tag_pipe
// Description : LATENCY-deep shift register of {valid, kill, id} tags that
//               mirrors the ops inside the shared resource.
//   clk, reset   : clock, synchronous active-low reset
//   load_valid   : an op is issued this cycle
//   load_id      : issuing requester
//   flush        : per-requester kill of every in-flight op with that id
//   out_tag      : tag aligned with the resource result this cycle
//   inflight_cnt : number of valid stages
// Revision    : 1.0  initial release
// ============================================================================
module sched_tag_pipe
  import sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int LATENCY   = 3,
  parameter int CNT_OUT_W = $clog2(LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [REQ_ID_W-1:0]  load_id,
  input  logic [NUM_REQ-1:0]   flush,
  output tag_t                 out_tag,
  output logic [CNT_OUT_W-1:0] inflight_cnt
);

  tag_t r_stage [LATENCY];
  tag_t w_next  [LATENCY];

  // Next contents of each stage, with flush kills applied on the way in so
  // the op being loaded this cycle is covered too.
  always_comb begin
    w_next[0].valid = load_valid;
    w_next[0].kill  = 1'b0;
    w_next[0].id    = load_id;
    for (int k = 1; k < LATENCY; k++) begin
      w_next[k] = r_stage[k-1];
    end
    for (int k = 0; k < LATENCY; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush[i] && w_next[k].valid && (w_next[k].id == REQ_ID_W'(i))) begin
          w_next[k].kill = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LATENCY; k++) r_stage[k] <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++) r_stage[k] <= w_next[k];
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int k = 0; k < LATENCY; k++) begin
      inflight_cnt = inflight_cnt + CNT_OUT_W'(r_stage[k].valid);
    end
  end

  assign out_tag = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/shared_resource_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : shared_resource_scheduler
// Description : Shares one fixed-latency resource between NUM_REQ pipelines.
//               Round-robin issue with bounded bursts, per-requester stalls,
//               owner tracking that routes results back, per-requester flush
//               and a global drain.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : shared_resource_scheduler_if.slave (requests, grants, results,
//           drain handshake, sticky error)
//   Optional macro SCHED_PERF_CNT_EN: saturating 16-bit per-requester grant
//   and stall cycle counters on bus.perf_grants / bus.perf_stalls.
// Revision    : 1.0  initial release
// ============================================================================
module shared_resource_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int LATENCY   = 3,
  parameter int MAX_BURST = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  shared_resource_scheduler_if.slave bus
);

  localparam int c_SEL_W = $clog2(NUM_REQ);
  localparam int c_IFL_W = $clog2(LATENCY + 1);

  sched_state_t        r_state, w_state_next;
  logic [REQ_ID_W-1:0] r_ptr, r_last, w_gnt_id, w_ptr_next;
  logic [CNT_W-1:0]    r_burst, w_burst_next;
  logic                r_err;
  logic [NUM_REQ-1:0]  w_elig, w_grant, w_stall, w_rsp;
  logic [REQ_ID_W:0]   w_pick;
  logic                w_can_issue, w_last_elig, w_regrant, w_gnt_any;
  logic                w_drain_done;
  tag_t                w_tag_out;
  logic [c_IFL_W-1:0]  w_inflight;

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    w_elig      = bus.req & ~bus.req_flush;
    // A drain request blocks issue in the very cycle it appears.
    w_can_issue = reset && (r_state == ST_RUN) && !bus.drain_req && bus.res_ready;

    w_last_elig = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_elig[i] && (r_last == REQ_ID_W'(i))) w_last_elig = 1'b1;
    end

    w_pick    = rr_pick(MAX_NUM_REQ'(w_elig), r_ptr, NUM_REQ);
    // r_burst==0 means nothing has been granted since reset.
    w_regrant = (r_burst != '0) && w_last_elig && (r_burst < CNT_W'(MAX_BURST));
    w_gnt_id  = w_regrant ? r_last : w_pick[REQ_ID_W-1:0];
    w_gnt_any = w_can_issue && (w_regrant || w_pick[REQ_ID_W]);

    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_grant[i] = w_gnt_any && (w_gnt_id == REQ_ID_W'(i));
    end
    w_stall = reset ? (bus.req & ~w_grant) : '0;

    w_ptr_next = (w_gnt_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    // Consecutive grants to the same requester extend the burst; the count
    // saturates at MAX_BURST, which is exactly where regrant stops.
    if ((r_burst != '0) && (w_gnt_id == r_last)) begin
      w_burst_next = (r_burst < CNT_W'(MAX_BURST)) ? r_burst + 1'b1 : r_burst;
    end else begin
      w_burst_next = CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------- FSM
  always_comb begin
    w_state_next = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.drain_req) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_inflight == '0) w_state_next = ST_IDLE_DRAINED;
      end
      ST_IDLE_DRAINED: begin
        w_drain_done = reset;
        if (!bus.drain_req) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_ptr   <= '0;
      r_last  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_gnt_any) begin
        r_ptr   <= w_ptr_next;
        r_last  <= w_gnt_id;
        r_burst <= w_burst_next;
      end
      // A result without a matching tag, or a missing result, is sticky.
      if (bus.res_out_valid != w_tag_out.valid) r_err <= 1'b1;
    end
  end

  // ------------------------------------------------------- result routing
  sched_tag_pipe #(
    .NUM_REQ   (NUM_REQ),
    .LATENCY   (LATENCY),
    .CNT_OUT_W (c_IFL_W)
  ) u_tag_pipe (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (w_gnt_any),
    .load_id      (w_gnt_id),
    .flush        (bus.req_flush),
    .out_tag      (w_tag_out),
    .inflight_cnt (w_inflight)
  );

  always_comb begin
    w_rsp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp[i] = reset && bus.res_out_valid && w_tag_out.valid && !w_tag_out.kill
                 && (w_tag_out.id == REQ_ID_W'(i));
    end
  end

  assign bus.grant        = w_grant;
  assign bus.stall        = w_stall;
  assign bus.res_in_valid = w_gnt_any;
  assign bus.res_in_sel   = c_SEL_W'(w_gnt_id);
  assign bus.rsp_valid    = w_rsp;
  assign bus.inflight_cnt = w_inflight;
  assign bus.drain_done   = w_drain_done;
  assign bus.err_rsp      = r_err;

`ifdef SCHED_PERF_CNT_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [15:0] r_grants, r_stalls;
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_grants <= '0;
        r_stalls <= '0;
      end else begin
        if (w_grant[gi] && (r_grants != 16'hFFFF)) r_grants <= r_grants + 16'd1;
        if (w_stall[gi] && (r_stalls != 16'hFFFF)) r_stalls <= r_stalls + 16'd1;
      end
    end
    assign bus.perf_grants[gi*16 +: 16] = r_grants;
    assign bus.perf_stalls[gi*16 +: 16] = r_stalls;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shared_resource_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_resource_scheduler
// Description : Directed scoreboard bench. dut_a runs MAX_BURST=1, dut_b runs
//               MAX_BURST=2; both see the same requests, each has its own
//               3-cycle resource model. The driver queues hand-computed
//               expected outputs per cycle; a monitor pops and compares them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shared_resource_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, req_flush;
  logic       res_ready, drain_req, inj_b;
  logic [2:0] pipe_a = '0;
  logic [2:0] pipe_b = '0;

  always #5 clk = ~clk;

  shared_resource_scheduler_if #(.NUM_REQ(2), .LATENCY(3)) if_a ();
  shared_resource_scheduler_if #(.NUM_REQ(2), .LATENCY(3)) if_b ();

  assign if_a.req       = req;
  assign if_a.req_flush = req_flush;
  assign if_a.res_ready = res_ready;
  assign if_a.drain_req = drain_req;
  assign if_b.req       = req;
  assign if_b.req_flush = req_flush;
  assign if_b.res_ready = res_ready;
  assign if_b.drain_req = drain_req;

  // Resource models: result valid exactly 3 cycles after issue.
  always @(posedge clk) begin
    pipe_a <= {pipe_a[1:0], if_a.res_in_valid};
    pipe_b <= {pipe_b[1:0], if_b.res_in_valid};
  end
  assign if_a.res_out_valid = pipe_a[2];
  assign if_b.res_out_valid = pipe_b[2] | inj_b;

  shared_resource_scheduler #(.NUM_REQ(2), .LATENCY(3), .MAX_BURST(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  shared_resource_scheduler #(.NUM_REQ(2), .LATENCY(3), .MAX_BURST(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));

  // mask bits: 0 grant(+res_in_valid) 1 stall 2 rsp_valid 3 inflight 4 drain_done 5 err
  typedef struct packed {
    logic [1:0] duts;
    logic [1:0] grant;
    logic [1:0] stall;
    logic [1:0] rsp;
    logic [1:0] infl;
    logic       dd;
    logic       err;
    logic [5:0] mask;
  } exp_t;

  localparam logic [5:0] ALL = 6'h3f;
  localparam logic [1:0] DA  = 2'b01;
  localparam logic [1:0] DB  = 2'b10;

  exp_t  exp_q [$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string nm, input string fld, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b", nm, fld, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] duts, input logic [1:0] g, input logic [1:0] s,
                      input logic [1:0] r, input logic [1:0] inf, input logic dd,
                      input logic er, input logic [5:0] m, input string nm);
    exp_t x;
    x.duts = duts; x.grant = g; x.stall = s; x.rsp = r; x.infl = inf;
    x.dd = dd; x.err = er; x.mask = m;
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  // Monitor
  initial begin
    exp_t       e;
    string      nm;
    logic [1:0] g, s, r, inf;
    logic       riv, dd, er;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          if (e.duts[d]) begin
            g   = (d == 0) ? if_a.grant        : if_b.grant;
            s   = (d == 0) ? if_a.stall        : if_b.stall;
            r   = (d == 0) ? if_a.rsp_valid    : if_b.rsp_valid;
            inf = (d == 0) ? if_a.inflight_cnt : if_b.inflight_cnt;
            riv = (d == 0) ? if_a.res_in_valid : if_b.res_in_valid;
            dd  = (d == 0) ? if_a.drain_done   : if_b.drain_done;
            er  = (d == 0) ? if_a.err_rsp      : if_b.err_rsp;
            if (e.mask[0]) begin
              chk(nm, (d == 0) ? "a.grant" : "b.grant", g, e.grant);
              chk(nm, (d == 0) ? "a.res_in_valid" : "b.res_in_valid", {1'b0, riv},
                  {1'b0, |e.grant});
            end
            if (e.mask[1]) chk(nm, (d == 0) ? "a.stall" : "b.stall", s, e.stall);
            if (e.mask[2]) chk(nm, (d == 0) ? "a.rsp_valid" : "b.rsp_valid", r, e.rsp);
            if (e.mask[3]) chk(nm, (d == 0) ? "a.inflight" : "b.inflight", inf, e.infl);
            if (e.mask[4]) chk(nm, (d == 0) ? "a.drain_done" : "b.drain_done",
                               {1'b0, dd}, {1'b0, e.dd});
            if (e.mask[5]) chk(nm, (d == 0) ? "a.err_rsp" : "b.err_rsp",
                               {1'b0, er}, {1'b0, e.err});
          end
        end
      end
    end
  end

  // Driver
  initial begin
    reset = 1'b0; req = 2'b00; req_flush = 2'b00;
    res_ready = 1'b1; drain_req = 1'b0; inj_b = 1'b0;
    @(posedge clk); #1;
    req = 2'b11;
    step(DA | DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "reset");

    // 1: pure round robin on dut_a
    reset = 1'b1; req = 2'b11;
    step(DA, 2'b01, 2'b10, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "rr_c0");
    step(DA, 2'b10, 2'b01, 2'b00, 2'd1, 1'b0, 1'b0, ALL, "rr_c1");
    step(DA, 2'b01, 2'b10, 2'b00, 2'd2, 1'b0, 1'b0, ALL, "rr_c2");
    step(DA, 2'b10, 2'b01, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "rr_c3");
    step(DA, 2'b01, 2'b10, 2'b10, 2'd3, 1'b0, 1'b0, ALL, "rr_c4");
    step(DA, 2'b10, 2'b01, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "rr_c5");
    req = 2'b00;
    step(DA, 2'b00, 2'b00, 2'b10, 2'd3, 1'b0, 1'b0, ALL, "rr_c6");
    step(DA, 2'b00, 2'b00, 2'b01, 2'd2, 1'b0, 1'b0, ALL, "rr_c7");
    step(DA, 2'b00, 2'b00, 2'b10, 2'd1, 1'b0, 1'b0, ALL, "rr_c8");
    step(DA, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "rr_c9");

    // 2: bursts of two on dut_b
    reset = 1'b0; req = 2'b11;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "rst2");
    reset = 1'b1;
    step(DB, 2'b01, 2'b10, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "burst_d0");
    step(DB, 2'b01, 2'b10, 2'b00, 2'd1, 1'b0, 1'b0, ALL, "burst_d1");
    step(DB, 2'b10, 2'b01, 2'b00, 2'd2, 1'b0, 1'b0, ALL, "burst_d2");
    step(DB, 2'b10, 2'b01, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "burst_d3");
    step(DB, 2'b01, 2'b10, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "burst_d4");
    step(DB, 2'b01, 2'b10, 2'b10, 2'd3, 1'b0, 1'b0, ALL, "burst_d5");
    req = 2'b01;
    step(DB, 2'b01, 2'b00, 2'b10, 2'd3, 1'b0, 1'b0, ALL, "burst_d6");
    step(DB, 2'b01, 2'b00, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "burst_d7");
    step(DB, 2'b01, 2'b00, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "burst_d8");
    req = 2'b00;
    step(DB, 2'b00, 2'b00, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "burst_d9");
    step(DB, 2'b00, 2'b00, 2'b01, 2'd2, 1'b0, 1'b0, ALL, "burst_d10");
    step(DB, 2'b00, 2'b00, 2'b01, 2'd1, 1'b0, 1'b0, ALL, "burst_d11");
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "burst_d12");

    // 3: flush of an in-flight op
    reset = 1'b0;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "rst3");
    reset = 1'b1; req = 2'b01;
    step(DB, 2'b01, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "flush_t0");
    req = 2'b00; req_flush = 2'b01;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd1, 1'b0, 1'b0, ALL, "flush_t1");
    req = 2'b10; req_flush = 2'b00;
    step(DB, 2'b10, 2'b00, 2'b00, 2'd1, 1'b0, 1'b0, ALL, "flush_t2");
    req = 2'b00;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd2, 1'b0, 1'b0, ALL, "flush_t3");
    step(DB, 2'b00, 2'b00, 2'b00, 2'd1, 1'b0, 1'b0, ALL, "flush_t4");
    step(DB, 2'b00, 2'b00, 2'b10, 2'd1, 1'b0, 1'b0, ALL, "flush_t5");
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "flush_t6");

    // 4: drain
    reset = 1'b0;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "rst4");
    reset = 1'b1; req = 2'b01;
    step(DB, 2'b01, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "drain_e0");
    step(DB, 2'b01, 2'b00, 2'b00, 2'd1, 1'b0, 1'b0, ALL, "drain_e1");
    step(DB, 2'b01, 2'b00, 2'b00, 2'd2, 1'b0, 1'b0, ALL, "drain_e2");
    drain_req = 1'b1;
    step(DB, 2'b00, 2'b01, 2'b01, 2'd3, 1'b0, 1'b0, ALL, "drain_e3");
    step(DB, 2'b00, 2'b01, 2'b01, 2'd2, 1'b0, 1'b0, ALL, "drain_e4");
    step(DB, 2'b00, 2'b01, 2'b01, 2'd1, 1'b0, 1'b0, ALL, "drain_e5");
    step(DB, 2'b00, 2'b01, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "drain_e6");
    step(DB, 2'b00, 2'b01, 2'b00, 2'd0, 1'b1, 1'b0, ALL, "drain_e7");
    drain_req = 1'b0;
    step(DB, 2'b00, 2'b01, 2'b00, 2'd0, 1'b1, 1'b0, ALL, "drain_e8");
    step(DB, 2'b01, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "drain_e9");
    req = 2'b00;
    repeat (4) begin @(posedge clk); #1; end

    // 5: resource not ready, spurious result, reset clears
    reset = 1'b0;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "rst5");
    reset = 1'b1; req = 2'b01; res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(DB, 2'b00, 2'b01, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "notready");
    end
    req = 2'b00; inj_b = 1'b1;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "spur_f4");
    inj_b = 1'b0;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b1, ALL, "spur_f5");
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b1, ALL, "spur_f6");
    reset = 1'b0; req = 2'b11; res_ready = 1'b1;
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b1, ALL, "rstin_f7");
    step(DB, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, ALL, "rstin_f8");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
